// File: rtl/iceboard_regbank_if.sv
// rtl/iceboard_regbank_if.sv - Avalon-MM style register bus for iceboard_regbank
interface iceboard_regbank_if;
    logic [15:0] address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, write, writedata, read, input readdata, waitrequest);
    modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/iceboard_regbank.sv
// rtl/iceboard_regbank.sv - motor config/status register bank with commit handshake (optional ICEBOARD_SHADOW_COMMIT_EN)
module iceboard_regbank #(
    parameter int NUMBER_OF_MOTORS = 8,
    parameter int SP_WIDTH         = 24,
    parameter int GAIN_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    iceboard_regbank_if.slave                      bus,
    output logic                                   cfg_valid,
    input  logic                                   cfg_ready,
    output logic [NUMBER_OF_MOTORS*SP_WIDTH-1:0]   sp_o,
    output logic [NUMBER_OF_MOTORS*SP_WIDTH-1:0]   pwmlimit_o,
    output logic [NUMBER_OF_MOTORS*GAIN_WIDTH-1:0] kp_o,
    output logic [NUMBER_OF_MOTORS*GAIN_WIDTH-1:0] ki_o,
    output logic [NUMBER_OF_MOTORS*GAIN_WIDTH-1:0] kd_o,
    output logic [NUMBER_OF_MOTORS*8-1:0]          mode_o,
    output logic [NUMBER_OF_MOTORS*8-1:0]          id_o,
    input  logic                                   status_valid,
    input  logic [NUMBER_OF_MOTORS*SP_WIDTH-1:0]   enc_i,
    input  logic [NUMBER_OF_MOTORS*32-1:0]         err_i
);
    localparam int N  = NUMBER_OF_MOTORS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SP_WIDTH-1:0] PWM_RESET = {1'b0, {(SP_WIDTH-1){1'b1}}};

    localparam logic [7:0] R_ID = 8'h00, R_KP = 8'h01, R_KI = 8'h02, R_KD = 8'h03;
    localparam logic [7:0] R_ENC = 8'h04, R_PWM = 8'h08, R_MODE = 8'h0B, R_SP = 8'h0C;
    localparam logic [7:0] R_ERR = 8'h0D, R_COMMIT = 8'h20, R_FLAGS = 8'h21, R_COUNT = 8'h22;

    typedef logic [SP_WIDTH-1:0]   sp_t;
    typedef logic [GAIN_WIDTH-1:0] gain_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Active bank drives the comms outputs; the *_s names are what the bus sees
    sp_t         sp_a [N], pwm_a [N], sp_s [N], pwm_s [N];
    gain_t       kp_a [N], ki_a [N], kd_a [N], kp_s [N], ki_s [N], kd_s [N];
    logic [7:0]  mode_a [N], id_a [N], mode_s [N], id_s [N];
    sp_t         enc_q [N];
    logic [31:0] err_q [N];
    logic [1:0]  flags;
    logic [31:0] count;

    rd_state_t   rd_state, rd_next;
    logic [7:0]  reg_sel, idx;
    logic [IW-1:0] midx;
    logic        idx_ok, is_cfg_reg, is_motor_reg, is_glob_reg, bad_addr;
    logic        rd_cap, rd_acc, wr_acc, cfg_wr, commit_ev, busy, commit_ok;
    logic        overrun_ev, addr_err_ev;
    logic [1:0]  flag_clr;
    logic [31:0] rd_val;

    // Upper write-data bits beyond the narrowest fields are intentionally dropped
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.writedata};

    assign reg_sel      = bus.address[15:8];
    assign idx          = bus.address[7:0];
    assign midx         = idx[IW-1:0];
    assign idx_ok       = ({24'b0, idx} < 32'(N));
    assign is_cfg_reg   = (reg_sel == R_ID) || (reg_sel == R_KP) || (reg_sel == R_KI) ||
                          (reg_sel == R_KD) || (reg_sel == R_PWM) || (reg_sel == R_MODE) ||
                          (reg_sel == R_SP);
    assign is_motor_reg = is_cfg_reg || (reg_sel == R_ENC) || (reg_sel == R_ERR);
    assign is_glob_reg  = (reg_sel == R_COMMIT) || (reg_sel == R_FLAGS) || (reg_sel == R_COUNT);
    assign bad_addr     = is_motor_reg ? !idx_ok : !is_glob_reg;

    assign rd_cap = bus.read && (rd_state == RD_IDLE);
    assign rd_acc = bus.read && (rd_state == RD_DATA);
    assign wr_acc = bus.write && !bus.waitrequest;
    assign cfg_wr = wr_acc && is_cfg_reg && idx_ok;

`ifdef ICEBOARD_SHADOW_COMMIT_EN
    assign commit_ev = wr_acc && (reg_sel == R_COMMIT);
`else
    assign commit_ev = cfg_wr;
    assign sp_s = sp_a;
    assign pwm_s = pwm_a;
    assign kp_s = kp_a;
    assign ki_s = ki_a;
    assign kd_s = kd_a;
    assign mode_s = mode_a;
    assign id_s = id_a;
`endif

    // A handshake completing in the same cycle frees the bank for a new commit
    assign busy        = cfg_valid && !cfg_ready;
    assign commit_ok   = commit_ev && !busy;
    assign overrun_ev  = commit_ev && busy;
    assign addr_err_ev = bad_addr && (wr_acc || rd_acc);
    // Only flags that were actually reported get cleared, so later events survive
    assign flag_clr    = (rd_acc && reg_sel == R_FLAGS) ? bus.readdata[1:0] : 2'b00;

    // Read state register: one wait cycle per read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    // Read next-state and stall generation
    always_comb begin
        rd_next         = RD_IDLE;
        bus.waitrequest = 1'b0;
        if (bus.read && rd_state == RD_IDLE) begin
            rd_next         = RD_DATA;
            bus.waitrequest = 1'b1;
        end
    end

    // Read data mux with sign extension of signed fields
    always_comb begin
        rd_val = 32'hDEADBEEF;
        if (!bad_addr) begin
            case (reg_sel)
                R_ID:    rd_val = {24'b0, id_s[midx]};
                R_KP:    rd_val = 32'($signed(kp_s[midx]));
                R_KI:    rd_val = 32'($signed(ki_s[midx]));
                R_KD:    rd_val = 32'($signed(kd_s[midx]));
                R_PWM:   rd_val = 32'($signed(pwm_s[midx]));
                R_MODE:  rd_val = {24'b0, mode_s[midx]};
                R_SP:    rd_val = 32'($signed(sp_s[midx]));
                R_ENC:   rd_val = 32'($signed(enc_q[midx]));
                R_ERR:   rd_val = err_q[midx];
                R_FLAGS: rd_val = {30'b0, flags};
                R_COUNT: rd_val = count;
                default: rd_val = 32'h0;
            endcase
        end
    end

    // Read data capture, sticky flags, commit handshake and commit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
            flags        <= '0;
            count        <= '0;
            cfg_valid    <= 1'b0;
        end else begin
            if (rd_cap) bus.readdata <= rd_val;
            flags <= (flags & ~flag_clr) | {addr_err_ev, overrun_ev};
            if (commit_ok) begin
                cfg_valid <= 1'b1;
                count     <= count + 32'd1;
            end else if (cfg_valid && cfg_ready) begin
                cfg_valid <= 1'b0;
            end
        end
    end

    // Status snapshot: every motor captured on the same strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                enc_q[i] <= '0;
                err_q[i] <= '0;
            end
        end else if (status_valid) begin
            for (int i = 0; i < N; i++) begin
                enc_q[i] <= enc_i[i*SP_WIDTH +: SP_WIDTH];
                err_q[i] <= err_i[i*32 +: 32];
            end
        end
    end

    // Configuration banks: reset image, register writes and commit transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                id_a[i] <= 8'(i + 1);  kp_a[i] <= GAIN_WIDTH'(1); ki_a[i] <= '0;  kd_a[i] <= '0;
                pwm_a[i] <= PWM_RESET; mode_a[i] <= 8'd3;         sp_a[i] <= '0;
`ifdef ICEBOARD_SHADOW_COMMIT_EN
                id_s[i] <= 8'(i + 1);  kp_s[i] <= GAIN_WIDTH'(1); ki_s[i] <= '0;  kd_s[i] <= '0;
                pwm_s[i] <= PWM_RESET; mode_s[i] <= 8'd3;         sp_s[i] <= '0;
`endif
            end
        end else begin
`ifdef ICEBOARD_SHADOW_COMMIT_EN
            if (cfg_wr) begin
                case (reg_sel)
                    R_ID:    id_s[midx]   <= bus.writedata[7:0];
                    R_KP:    kp_s[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_KI:    ki_s[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_KD:    kd_s[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_PWM:   pwm_s[midx]  <= bus.writedata[SP_WIDTH-1:0];
                    R_MODE:  mode_s[midx] <= bus.writedata[7:0];
                    R_SP:    sp_s[midx]   <= bus.writedata[SP_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (commit_ok) begin
                for (int i = 0; i < N; i++) begin
                    id_a[i] <= id_s[i];   kp_a[i] <= kp_s[i];     ki_a[i] <= ki_s[i]; kd_a[i] <= kd_s[i];
                    pwm_a[i] <= pwm_s[i]; mode_a[i] <= mode_s[i]; sp_a[i] <= sp_s[i];
                end
            end
`else
            if (commit_ok) begin
                case (reg_sel)
                    R_ID:    id_a[midx]   <= bus.writedata[7:0];
                    R_KP:    kp_a[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_KI:    ki_a[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_KD:    kd_a[midx]   <= bus.writedata[GAIN_WIDTH-1:0];
                    R_PWM:   pwm_a[midx]  <= bus.writedata[SP_WIDTH-1:0];
                    R_MODE:  mode_a[midx] <= bus.writedata[7:0];
                    R_SP:    sp_a[midx]   <= bus.writedata[SP_WIDTH-1:0];
                    default: ;
                endcase
            end
`endif
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign sp_o[g*SP_WIDTH +: SP_WIDTH]       = sp_a[g];
        assign pwmlimit_o[g*SP_WIDTH +: SP_WIDTH] = pwm_a[g];
        assign kp_o[g*GAIN_WIDTH +: GAIN_WIDTH]   = kp_a[g];
        assign ki_o[g*GAIN_WIDTH +: GAIN_WIDTH]   = ki_a[g];
        assign kd_o[g*GAIN_WIDTH +: GAIN_WIDTH]   = kd_a[g];
        assign mode_o[g*8 +: 8]                   = mode_a[g];
        assign id_o[g*8 +: 8]                     = id_a[g];
    end
endmodule

// File: doc/iceboard_regbank.md
ICEBOARD_REGBANK -- requirements
Module: iceboard_regbank

Interface
REQ-001 SHALL have parameters: NUMBER_OF_MOTORS, 8, motor channels (1..64); SP_WIDTH, 24, setpoint/encoder/PWMLimit width; GAIN_WIDTH, 16, Kp/Ki/Kd width.
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- reset  in  1  async active-high reset
- address  in  16  [15:8] register, [7:0] motor index
- write  in  1  Avalon write
- writedata  in  32  write data
- read  in  1  Avalon read
- readdata  out  32  read data
- waitrequest  out  1  Avalon stall
- cfg_valid  out  1  active config bank valid for comms
- cfg_ready  in  1  comms accepts bank
- sp_o, pwmlimit_o  out  NUMBER_OF_MOTORS*SP_WIDTH  flattened active config
- kp_o, ki_o, kd_o  out  NUMBER_OF_MOTORS*GAIN_WIDTH  flattened active gains
- mode_o, id_o  out  NUMBER_OF_MOTORS*8  control mode, motor id
- status_valid  in  1  status capture strobe
- enc_i  in  NUMBER_OF_MOTORS*SP_WIDTH  encoder positions
- err_i  in  NUMBER_OF_MOTORS*32  error codes

Function
REQ-003 Map: 0x00 id, 0x01 Kp, 0x02 Ki, 0x03 Kd, 0x08 PWMLimit, 0x0B mode, 0x0C sp (RW per motor); 0x04 enc, 0x0D err (RO per motor); 0x20 commit (WO), 0x21 flags (RO), 0x22 commit count (RO).
REQ-004 Read: waitrequest high in the first cycle of read, low in the second; readdata valid while read && !waitrequest; held until next read.
REQ-005 Write: accepted in cycle of write && !waitrequest; no stall; data truncated to field width.
REQ-006 Signed fields (sp, gains, PWMLimit, enc) sign-extended on read; id/mode zero-extended.
REQ-007 Motor index >= NUMBER_OF_MOTORS or unmapped register: read returns 32'hDEADBEEF, write ignored, flags[1] (addr error) set sticky.
REQ-008 enc/err snapshot registers update only on status_valid; all motors captured same cycle.
REQ-009 Handshake: cfg_valid rises on a commit event; all *_o stable while cfg_valid high; cfg_valid falls the cycle after cfg_valid && cfg_ready.
REQ-010 Commit event while cfg_valid high: ignored, flags[0] (overrun) set sticky, *_o unchanged.
REQ-011 Commit count (32 bit) increments per accepted commit, wraps 0xFFFFFFFF->0.
REQ-012 Read of 0x21 returns {30'b0, addr_err, overrun} then clears both; a flag event in the same cycle wins (stays set).
REQ-013 Simultaneous cfg_ready handshake completion and new commit: commit accepted, cfg_valid stays high.

Reset
REQ-014 On reset: per motor i Kp=1, Ki=Kd=sp=0, mode=3, PWMLimit=2^(SP_WIDTH-1)-1, id=i+1, in shadow and active banks; enc, err, count, flags=0; cfg_valid=0; readdata=0; waitrequest=read.
REQ-015 Reset asserted mid-read or mid-handshake aborts it; no commit survives.

Configuration
REQ-016 Macro ICEBOARD_SHADOW_COMMIT_EN defined: writes go to shadow bank; reads return shadow; write to 0x20 is the commit event, copying full shadow to active in one cycle.
REQ-017 Macro undefined: no shadow bank; writes update active directly only when cfg_valid low (else dropped, overrun set); each accepted config write is a commit event; 0x20 writes ignored.

Verification
REQ-018 Reset, read 0x0100 (Kp m0) -> waitrequest 1 cycle, readdata 0x00000001; read 0x0C07 -> 0; read 0x0007 -> 0x00000008.
REQ-019 With macro: write 0x0C02=0xFFFFFF80, read -> 0xFFFFFF80, sp_o[2] still 0; write 0x2000 -> next cycle sp_o[2]=-128, cfg_valid=1, count=1.
REQ-020 cfg_ready held 0, second commit -> *_o unchanged, 0x21 reads 0x1 then 0x0; cfg_ready=1 -> cfg_valid low next cycle.
REQ-021 Read 0x0108 with NUMBER_OF_MOTORS=8 -> 0xDEADBEEF, flags=0x2; write 0x0C08 -> no output change.
REQ-022 Drive enc_i motor3=0x800000, pulse status_valid, read 0x0403 -> 0xFF800000; change enc_i without strobe -> unchanged.
REQ-023 Without macro: write 0x0B01=5 -> mode_o[1]=5, cfg_valid=1 next cycle; second write before cfg_ready -> dropped, overrun set.
